// File: rtl/fifo_avalon_ctrl.sv
// Avalon-MM CSR-mapped FIFO with sticky flags, thresholds and flush.
// Optional level interrupt and IRQ_MASK register enabled by macro FIFO_IRQ_EN.
module fifo_avalon_ctrl #(
   parameter int WIDTH         = 8,
   parameter int POINTER_WIDTH = 4,
   parameter int DEPTH         = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       avalon_address,
   input  logic             avalon_write,
   input  logic             avalon_read,
   input  logic [WIDTH-1:0] avalon_writedata,
   output logic [WIDTH-1:0] avalon_readdata,
   output logic [1:0]       avalon_status,
   output logic             irq
);
   localparam int CW = POINTER_WIDTH + 1;

   logic [WIDTH-1:0]         mem [DEPTH];
   logic [POINTER_WIDTH-1:0] wr_ptr;
   logic [POINTER_WIDTH-1:0] rd_ptr;
   logic [CW-1:0]            count;
   logic [CW-1:0]            af_thresh;
   logic [CW-1:0]            ae_thresh;
   logic                     overflow;
   logic                     underflow;
   logic [3:0]               irq_mask;
   logic                     full;
   logic                     empty;
   logic [5:0]               status;
   logic                     wr;
   logic                     rd;
   logic                     sel_data;
   logic                     push;
   logic                     pop;
   logic                     flush;
   logic                     sts_wr;
   logic [WIDTH-1:0]         rd_val;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign status   = {underflow, overflow,
                      (count >= af_thresh),
                      (count <= ae_thresh),
                      full, empty};
   assign avalon_status = {full, empty};

   // a read strobe coinciding with a write strobe is dropped
   assign wr       = avalon_write;
   assign rd       = avalon_read & ~avalon_write;
   assign sel_data = (avalon_address == 3'd0);
   assign push     = wr & sel_data & ~full;
   assign pop      = rd & sel_data & ~empty;
   assign sts_wr   = wr & (avalon_address == 3'd1);
   assign flush    = wr & (avalon_address == 3'd6) & avalon_writedata[0];

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= avalon_writedata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            count  <= count + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            count  <= count - 1'b1;
         end
      end
   end

   // set events take priority over a write-one-to-clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr & sel_data & full)
            overflow <= 1'b1;
         else if (sts_wr & avalon_writedata[4])
            overflow <= 1'b0;
         if (rd & sel_data & empty)
            underflow <= 1'b1;
         else if (sts_wr & avalon_writedata[5])
            underflow <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         af_thresh <= CW'(DEPTH - 2);
         ae_thresh <= CW'(2);
      end else if (wr) begin
         if (avalon_address == 3'd3)
            af_thresh <= avalon_writedata[CW-1:0];
         if (avalon_address == 3'd4)
            ae_thresh <= avalon_writedata[CW-1:0];
      end
   end

`ifdef FIFO_IRQ_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         irq_mask <= '0;
         irq      <= 1'b0;
      end else begin
         if (wr && avalon_address == 3'd5)
            irq_mask <= avalon_writedata[3:0];
         irq <= |(status[5:2] & irq_mask);
      end
   end
`else
   assign irq_mask = '0;
   assign irq      = 1'b0;
`endif

   always_comb begin
      rd_val = '0;
      case (avalon_address)
         3'd0: if (!empty) rd_val = mem[rd_ptr];
         3'd1: rd_val[5:0]    = status;
         3'd2: rd_val[CW-1:0] = count;
         3'd3: rd_val[CW-1:0] = af_thresh;
         3'd4: rd_val[CW-1:0] = ae_thresh;
         3'd5: rd_val[3:0]    = irq_mask;
         default: rd_val = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         avalon_readdata <= '0;
      else if (rd)
         avalon_readdata <= rd_val;
   end

endmodule

// File: tb/tb_fifo_avalon_ctrl.sv
// Randomized and directed bench for fifo_avalon_ctrl against a queue model.
// Honours FIFO_IRQ_EN the same way as the design.
module tb_fifo_avalon_ctrl;
   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] avalon_address;
   logic       avalon_write;
   logic       avalon_read;
   logic [7:0] avalon_writedata;
   logic [7:0] avalon_readdata;
   logic [1:0] avalon_status;
   logic       irq;

   int errors = 0;
   int checks = 0;

   logic [7:0] q[$];
   int         af;
   int         ae;
   bit         ovf;
   bit         unf;
   logic [3:0] mask;
   logic [7:0] last_rd;

   always #5 clk = ~clk;

   fifo_avalon_ctrl dut (
      .clk              (clk),
      .reset            (reset),
      .avalon_address   (avalon_address),
      .avalon_write     (avalon_write),
      .avalon_read      (avalon_read),
      .avalon_writedata (avalon_writedata),
      .avalon_readdata  (avalon_readdata),
      .avalon_status    (avalon_status),
      .irq              (irq)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] m_status();
      int n;
      n = q.size();
      return {2'b00, unf, ovf, 1'(n >= af), 1'(n <= ae),
              1'(n == 16), 1'(n == 0)};
   endfunction

   function automatic bit m_irq();
`ifdef FIFO_IRQ_EN
      logic [7:0] s;
      s = m_status();
      return |(s[5:2] & mask);
`else
      return 1'b0;
`endif
   endfunction

   task automatic m_reset();
      q.delete();
      af = 14; ae = 2; ovf = 0; unf = 0; mask = '0; last_rd = '0;
   endtask

   task automatic m_write(input logic [2:0] a, input logic [7:0] d);
      case (a)
         3'd0: if (q.size() < 16) q.push_back(d); else ovf = 1;
         3'd1: begin
            if (d[4]) ovf = 0;
            if (d[5]) unf = 0;
         end
         3'd3: af = int'(d % 32);
         3'd4: ae = int'(d % 32);
`ifdef FIFO_IRQ_EN
         3'd5: mask = d[3:0];
`endif
         3'd6: if (d[0]) q.delete();
         default: ;
      endcase
   endtask

   task automatic m_read(input logic [2:0] a, output logic [7:0] r);
      r = '0;
      case (a)
         3'd0: if (q.size() > 0) r = q.pop_front(); else unf = 1;
         3'd1: r = m_status();
         3'd2: r = 8'(q.size());
         3'd3: r = 8'(af);
         3'd4: r = 8'(ae);
         3'd5: r = {4'h0, mask};
         default: r = '0;
      endcase
   endtask

   task automatic do_op(input bit w, input bit r, input logic [2:0] a,
                        input logic [7:0] d);
      logic [7:0] exp_rd;
      bit         exp_irq;
      logic [7:0] s;
      exp_irq = m_irq();
      exp_rd  = last_rd;
      if (w) m_write(a, d);
      else if (r) m_read(a, exp_rd);
      @(negedge clk);
      avalon_write     = w;
      avalon_read      = r;
      avalon_address   = a;
      avalon_writedata = d;
      @(posedge clk);
      #1;
      avalon_write = 1'b0;
      avalon_read  = 1'b0;
      last_rd = exp_rd;
      s = m_status();
      check("readdata", avalon_readdata, exp_rd);
      check("avalon_status", avalon_status, s[1:0]);
      check("irq", irq, exp_irq);
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      do_op(1'b1, 1'b0, a, d);
   endtask

   task automatic rd(input logic [2:0] a);
      do_op(1'b0, 1'b1, a, 8'h00);
   endtask

   task automatic idle();
      do_op(1'b0, 1'b0, 3'd0, 8'h00);
   endtask

   initial begin
      logic [7:0] wv;
      int         sel;
      reset = 1'b0;
      avalon_address = '0;
      avalon_write = 1'b0;
      avalon_read = 1'b0;
      avalon_writedata = '0;
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_readdata", avalon_readdata, 8'h00);
      check("rst_status", avalon_status, 2'b01);
      check("rst_irq", irq, 1'b0);
      @(negedge clk);
      reset = 1'b1;

      // basic push/pop with 1-cycle read latency
      wr(0, 8'h11); wr(0, 8'h22); wr(0, 8'h33);
      rd(2);
      check("count3", avalon_readdata, 8'd3);
      rd(0); check("pop11", avalon_readdata, 8'h11);
      rd(0); check("pop22", avalon_readdata, 8'h22);
      rd(0); check("pop33", avalon_readdata, 8'h33);
      rd(2); check("count0", avalon_readdata, 8'd0);
      check("status01", avalon_status, 2'b01);

      // fill past full
      for (int i = 0; i <= 16; i++) wr(0, 8'(i));
      check("full", avalon_status, 2'b10);
      rd(1); check("ovf_bit", avalon_readdata[4], 1'b1);
      for (int i = 0; i < 16; i++) rd(0);
      rd(2); check("drained", avalon_readdata, 8'd0);
      wr(1, 8'h10);

      // underflow and clear
      rd(0); check("null_read", avalon_readdata, 8'h00);
      rd(1); check("unf_status", avalon_readdata, 8'h25);
      wr(1, 8'h20);
      rd(1); check("cleared", avalon_readdata, 8'h05);

      // pointer wrap
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 10; i++) wr(0, 8'(8'hA0 + i + 10 * k));
         for (int i = 0; i < 10; i++) rd(0);
      end
      rd(2); check("wrap_count", avalon_readdata, 8'd0);

`ifdef FIFO_IRQ_EN
      wr(3, 8'd4); wr(5, 8'h2);
      rd(5); check("mask_rb", avalon_readdata, 8'h02);
      for (int i = 0; i < 4; i++) wr(0, 8'(i));
      check("irq_pre", irq, 1'b0);
      idle(); check("irq_af", irq, 1'b1);
      wr(6, 8'h1);
      idle(); check("irq_flush", irq, 1'b0);
      rd(2); check("flush_count", avalon_readdata, 8'd0);
      wr(5, 8'h0);
`else
      wr(5, 8'hF);
      rd(5); check("mask_off", avalon_readdata, 8'h00);
`endif
      wr(3, 8'd14);
      wr(4, 8'd2);

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         sel = $urandom_range(0, 99);
         wv  = 8'($urandom);
         if (sel < 38)      wr(0, wv);
         else if (sel < 72) rd(0);
         else if (sel < 80) rd(3'($urandom_range(1, 7)));
         else if (sel < 84) wr(1, wv);
         else if (sel < 88) wr(3'($urandom_range(3, 4)), 8'($urandom_range(0, 40)));
         else if (sel < 90) wr(5, wv);
         else if (sel < 91) wr(7, wv);
         else if (sel < 92) wr(6, wv);
         else if (sel < 96) do_op(1'b1, 1'b1, 3'($urandom_range(0, 1)), wv);
         else               idle();
      end

      // reset in the middle of a write
      wr(6, 8'h1); wr(3, 8'd9); wr(4, 8'd7);
      for (int i = 0; i < 5; i++) wr(0, 8'(8'h50 + i));
      @(negedge clk);
      avalon_write = 1'b1;
      avalon_address = 3'd0;
      avalon_writedata = 8'h77;
      reset = 1'b0;
      #1;
      m_reset();
      check("mid_rst_rdata", avalon_readdata, 8'h00);
      check("mid_rst_status", avalon_status, 2'b01);
      check("mid_rst_irq", irq, 1'b0);
      @(posedge clk);
      #1;
      avalon_write = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      rd(2); check("rst_count", avalon_readdata, 8'd0);
      rd(3); check("rst_af", avalon_readdata, 8'd14);
      rd(4); check("rst_ae", avalon_readdata, 8'd2);
      rd(0); check("rst_empty", avalon_readdata, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
